// File: rtl/avg_ser_pkg.sv
// rtl/avg_ser_pkg.sv - shared constants and read-FSM encoding for avg_pair_serializer
package avg_ser_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int OVF_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND1 = 2'd1,
        ST_SEND2 = 2'd2
    } rd_state_e;

endpackage

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - first-word-fall-through pair FIFO, DEPTH entries of WIDTH bits
module pair_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/avg_pair_serializer.sv
// rtl/avg_pair_serializer.sv - serializes filter output pairs into framed words; AVG_SER_OVF_CNT_EN adds ovf_count
module avg_pair_serializer
    import avg_ser_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_ready,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eof,
    output logic              overflow
`ifdef AVG_SER_OVF_CNT_EN
    ,
    output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic                in_ready_q;
    logic                rise;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*DATA_W-1:0] fifo_dout;
    logic                hs;
    logic                drop;

    rd_state_e           state_q, state_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [DATA_W-1:0]   second_q, second_d;
    logic                m_valid_q, m_valid_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic                overflow_q, overflow_d;

    assign rise      = in_ready & ~in_ready_q;
    assign fifo_push = rise & ~fifo_full;
    assign drop      = rise & fifo_full;
    assign hs        = m_valid_q & m_ready;

    pair_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({in1, in2}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The popped entry's in2 half waits in second_q while in1 is on the bus.
    always_comb begin
        state_d   = state_q;
        m_data_d  = m_data_q;
        second_d  = second_q;
        m_valid_d = m_valid_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    m_data_d  = fifo_dout[2*DATA_W-1:DATA_W];
                    second_d  = fifo_dout[DATA_W-1:0];
                    m_valid_d = 1'b1;
                    state_d   = ST_SEND1;
                end
            end
            ST_SEND1: begin
                if (hs) begin
                    m_data_d = second_q;
                    state_d  = ST_SEND2;
                end
            end
            ST_SEND2: begin
                if (hs) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        m_data_d = fifo_dout[2*DATA_W-1:DATA_W];
                        second_d = fifo_dout[DATA_W-1:0];
                        state_d  = ST_SEND1;
                    end else begin
                        m_valid_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                m_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (hs) begin
            word_cnt_d = (word_cnt_q == CNT_LAST) ? '0 : word_cnt_q + CNT_W'(1);
        end
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q <= 1'b0;
            state_q    <= ST_IDLE;
            m_data_q   <= '0;
            second_q   <= '0;
            m_valid_q  <= 1'b0;
            word_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            in_ready_q <= in_ready;
            state_q    <= state_d;
            m_data_q   <= m_data_d;
            second_q   <= second_d;
            m_valid_q  <= m_valid_d;
            word_cnt_q <= word_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_sof    = m_valid_q && (word_cnt_q == '0);
    assign m_eof    = m_valid_q && (word_cnt_q == CNT_LAST);
    assign overflow = overflow_q;

`ifdef AVG_SER_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != {OVF_CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_avg_pair_serializer.sv
// tb/tb_avg_pair_serializer.sv - self-checking bench for avg_pair_serializer
module tb_avg_pair_serializer;

    localparam int DW = 12;
    localparam int FL = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_ready;
    logic [DW-1:0] in1, in2;
    logic [DW-1:0] m_data;
    logic          m_valid, m_ready, m_sof, m_eof, overflow;
`ifdef AVG_SER_OVF_CNT_EN
    logic [15:0]   ovf_count;
`endif

    avg_pair_serializer #(.DATA_W(DW), .FIFO_DEPTH(FD), .FRAME_LEN(FL)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_sof    (m_sof),
        .m_eof    (m_eof),
        .overflow (overflow)
`ifdef AVG_SER_OVF_CNT_EN
        ,
        .ovf_count(ovf_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eof;
    } obs_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            hold;
        logic          sof0;
        logic          eof1;
    } vec_t;

    obs_t          obs_q[$];
    logic [DW-1:0] exp_q[$];
    vec_t          tbl[4];
    int            checks   = 0;
    int            failures = 0;
    int            mdl_idx  = 0;
    bit            rnd_done;
    bit            mon_en   = 1'b1;

    always @(negedge clk) begin
        if (mon_en && reset_n && m_valid && m_ready) begin
            obs_q.push_back('{d: m_data, sof: m_sof, eof: m_eof});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_word(input string name, input logic [DW-1:0] d, input logic sof, input logic eof);
        obs_t o;
        if (obs_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_word required=%0h", name, d);
        end else begin
            o = obs_q.pop_front();
            check_val({name, "_data"}, 32'(o.d), 32'(d));
            check_val({name, "_sof"}, 32'(o.sof), 32'(sof));
            check_val({name, "_eof"}, 32'(o.eof), 32'(eof));
        end
        mdl_idx = (mdl_idx + 1) % FL;
    endtask

    task automatic model_word(input string name, input logic [DW-1:0] d);
        expect_word(name, d, mdl_idx == 0, mdl_idx == FL - 1);
    endtask

    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
        in1 = a;
        in2 = b;
        in_ready = 1'b1;
        repeat (hold) tick();
        in_ready = 1'b0;
        tick();
    endtask

    initial begin
        logic [DW-1:0] pa[6];
        logic [DW-1:0] pb[6];
        int            waited;

        tbl[0] = '{a: 12'hABC, b: 12'hDEF, hold: 1,  sof0: 1'b0, eof1: 1'b1};
        tbl[1] = '{a: 12'h000, b: 12'hFFF, hold: 10, sof0: 1'b1, eof1: 1'b0};
        tbl[2] = '{a: 12'hFFF, b: 12'h000, hold: 3,  sof0: 1'b0, eof1: 1'b1};
        tbl[3] = '{a: 12'h5A5, b: 12'hA5A, hold: 10, sof0: 1'b1, eof1: 1'b0};

        reset_n  = 1'b0;
        in_ready = 1'b0;
        in1      = '0;
        in2      = '0;
        m_ready  = 1'b1;
        repeat (3) tick();
        check_val("rst_valid", 32'(m_valid), 0);
        check_val("rst_data", 32'(m_data), 0);
        check_val("rst_sof", 32'(m_sof), 0);
        check_val("rst_eof", 32'(m_eof), 0);
        check_val("rst_ovf", 32'(overflow), 0);
        reset_n = 1'b1;
        tick();

        // single pair: latency and back-to-back word timing
        in1 = 12'h123;
        in2 = 12'h456;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        check_val("single_lat_valid", 32'(m_valid), 0);
        tick();
        check_val("single_w1_valid", 32'(m_valid), 1);
        check_val("single_w1_data", 32'(m_data), 32'h123);
        check_val("single_w1_sof", 32'(m_sof), 1);
        tick();
        check_val("single_w2_valid", 32'(m_valid), 1);
        check_val("single_w2_data", 32'(m_data), 32'h456);
        check_val("single_w2_sof", 32'(m_sof), 0);
        tick();
        check_val("single_end_valid", 32'(m_valid), 0);
        check_val("single_ovf", 32'(overflow), 0);
        check_val("single_count", 32'(obs_q.size()), 2);
        model_word("single_a", 12'h123);
        model_word("single_b", 12'h456);

        for (int i = 0; i < 4; i++) begin
            send_pair(tbl[i].a, tbl[i].b, tbl[i].hold);
            repeat (6) tick();
            check_val($sformatf("tbl%0d_count", i), 32'(obs_q.size()), 2);
            expect_word($sformatf("tbl%0d_w0", i), tbl[i].a, tbl[i].sof0, 1'b0);
            expect_word($sformatf("tbl%0d_w1", i), tbl[i].b, 1'b0, tbl[i].eof1);
        end

        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    logic [DW-1:0] ra, rb;
                    ra = DW'($urandom);
                    rb = DW'($urandom);
                    exp_q.push_back(ra);
                    exp_q.push_back(rb);
                    send_pair(ra, rb, $urandom_range(1, 4));
                    repeat ($urandom_range(16, 40)) tick();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    m_ready = ($urandom_range(3) != 0);
                    tick();
                end
            end
        join
        m_ready = 1'b1;
        repeat (10) tick();
        check_val("rnd_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int k = 0; exp_q.size() > 0; k++) begin
            model_word($sformatf("rnd%0d", k), exp_q.pop_front());
        end
        check_val("rnd_ovf", 32'(overflow), 0);

        // stall: FIFO plus output register hold FD+1 pairs, the next is dropped
        for (int k = 0; k < 6; k++) begin
            pa[k] = DW'(12'h100 + 12'(k * 17));
            pb[k] = DW'(12'h800 + 12'(k * 33));
        end
        m_ready = 1'b0;
        for (int k = 0; k < FD + 1; k++) begin
            send_pair(pa[k], pb[k], 1);
            repeat (31) tick();
            check_val($sformatf("bp%0d_valid", k), 32'(m_valid), 1);
            check_val($sformatf("bp%0d_data", k), 32'(m_data), 32'(pa[0]));
            check_val($sformatf("bp%0d_sof", k), 32'(m_sof), 32'(mdl_idx == 0));
            check_val($sformatf("bp%0d_eof", k), 32'(m_eof), 32'(mdl_idx == FL - 1));
        end
        check_val("bp_no_ovf", 32'(overflow), 0);
        send_pair(pa[5], pb[5], 1);
        repeat (3) tick();
        check_val("ovf_set", 32'(overflow), 1);
`ifdef AVG_SER_OVF_CNT_EN
        check_val("ovf_count", 32'(ovf_count), 1);
`endif
        m_ready = 1'b1;
        repeat (16) tick();
        check_val("drain_count", 32'(obs_q.size()), 2 * (FD + 1));
        for (int k = 0; k < FD + 1; k++) begin
            model_word($sformatf("drain%0d_a", k), pa[k]);
            model_word($sformatf("drain%0d_b", k), pb[k]);
        end
        check_val("drain_valid", 32'(m_valid), 0);
        check_val("ovf_sticky", 32'(overflow), 1);

        // asynchronous reset while a word is stalled on the bus
        m_ready = 1'b0;
        send_pair(12'h321, 12'h654, 1);
        waited = 0;
        while (!m_valid && waited < 20) begin
            tick();
            waited++;
        end
        check_val("mid_valid_before", 32'(m_valid), 1);
        reset_n = 1'b0;
        #1;
        check_val("mid_async_valid", 32'(m_valid), 0);
        check_val("mid_async_ovf", 32'(overflow), 0);
        tick();
        tick();
        reset_n = 1'b1;
        mdl_idx = 0;
        obs_q.delete();
        m_ready = 1'b1;
        repeat (10) tick();
        check_val("mid_idle_valid", 32'(m_valid), 0);
        check_val("mid_idle_count", 32'(obs_q.size()), 0);
`ifdef AVG_SER_OVF_CNT_EN
        check_val("mid_ovf_count", 32'(ovf_count), 0);
`endif
        send_pair(12'h777, 12'h888, 1);
        repeat (5) tick();
        model_word("post_rst_a", 12'h777);
        model_word("post_rst_b", 12'h888);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
